tff_timer_ctrl: RTL and testbench

- Programmable down-count timer controller.
- The count register is a bank of toggle-type flops; the controller sequences its toggle enables, loads, reloads and terminal-count events.
- Sits beside datapath blocks that need a periodic or one-shot strobe, such as sample enables and timeouts.
- Software-visible controls: start, stop, load value, and one-shot vs periodic mode.

---
 rtl/tff_timer_ctrl.sv | 144 ++++++++++++++
 tb/tb_tff_timer_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tff_timer_ctrl.sv
// tff_timer_ctrl: programmable down-count timer controller.
// The count register is a bank of toggle flops. Each bit toggles when all lower
// bits are zero, which yields count-1 without an adder.
// Optional prescaler: define TFF_TIMER_PRESCALE_EN. This also adds the PRESCALE_LOG2 parameter.
// With the macro defined, decrements happen once every 2^PRESCALE_LOG2 clocks.
module tff_timer_ctrl #(
    parameter int unsigned WIDTH = 8
`ifdef TFF_TIMER_PRESCALE_EN
    ,
    parameter int unsigned PRESCALE_LOG2 = 2
`endif
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tick,
    output logic             done
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_RUN  = 1'b1;

    logic             state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] toggle_c;
    logic             low_zero_c;
    logic             dec_en_c;

    // Toggle enables: bit i flips on decrement iff every bit below it is zero.
    always_comb begin
        low_zero_c = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            toggle_c[i] = low_zero_c;
            low_zero_c  = low_zero_c & ~count_q[i];
        end
    end

`ifdef TFF_TIMER_PRESCALE_EN
    localparam int unsigned PS_W = PRESCALE_LOG2;

    logic [PS_W-1:0] presc_q, presc_d;

    // Prescaler free-runs in RUN and is held at zero on load, stop and in IDLE.
    // A reload wraps it to zero on its own.
    always_comb begin
        presc_d = '0;
        if (state_q == S_RUN && !stop && !start) begin
            presc_d = presc_q + PS_W'(1);
        end
    end

    // The decrement fires on the cycle the prescaler is about to wrap to zero.
    assign dec_en_c = (presc_q == {PS_W{1'b1}});

    // Prescaler register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign dec_en_c = 1'b1;
`endif

    // Next-state logic. Priority order: stop, then start, then terminal count, then decrement.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mode_d  = mode_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        if (stop) begin
            state_d = S_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RUN;
                        count_d = load_val;
                        mode_d  = periodic;
                    end
                end
                S_RUN: begin
                    if (start) begin
                        count_d = load_val;
                        mode_d  = periodic;
                    end else if (dec_en_c) begin
                        if (count_q != '0) begin
                            count_d = count_q ^ toggle_c;
                        end else begin
                            tick_d = 1'b1;
                            if (mode_q) begin
                                count_d = load_val;
                                mode_d  = periodic;
                            end else begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // State, count and event registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            count_q <= '0;
            mode_q  <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign busy  = (state_q == S_RUN);
    assign tick  = tick_q;
    assign done  = done_q;

endmodule

// File: tb/tb_tff_timer_ctrl.sv
// tb_tff_timer_ctrl: vector table plus model-driven sequences for tff_timer_ctrl.
module tb_tff_timer_ctrl;

`ifdef TFF_TIMER_PRESCALE_EN
    localparam int PS_DIV = 4;
`else
    localparam int PS_DIV = 1;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic       stop;
    logic       periodic;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       busy;
    logic       tick;
    logic       done;

    always #5 clk = ~clk;

    tff_timer_ctrl dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .load_val (load_val),
        .count    (count),
        .busy     (busy),
        .tick     (tick),
        .done     (done)
    );

    typedef struct packed {
        logic [7:0] count;
        logic       busy;
        logic       tick;
        logic       done;
    } out_t;

    typedef struct {
        logic       start;
        logic       stop;
        logic       periodic;
        logic [7:0] load_val;
        out_t       want;
    } vec_t;

    vec_t vt[$];
    out_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Behavioural reference state.
    bit m_run;
    int m_count;
    bit m_mode;
    int m_ps;

    task automatic m_reset();
        m_run = 0; m_count = 0; m_mode = 0; m_ps = 0;
    endtask

    function automatic out_t m_step(input logic st, input logic sp, input logic per, input logic [7:0] lv);
        out_t o;
        o.tick = 1'b0;
        o.done = 1'b0;
        if (sp) begin
            m_run = 0; m_count = 0; m_ps = 0;
        end else if (st) begin
            m_run = 1; m_count = int'(lv); m_mode = per; m_ps = 0;
        end else if (m_run) begin
            if (m_ps == PS_DIV - 1) begin
                m_ps = 0;
                if (m_count > 0) begin
                    m_count = m_count - 1;
                end else begin
                    o.tick = 1'b1;
                    if (m_mode) begin
                        m_count = int'(lv);
                        m_mode  = per;
                    end else begin
                        m_run  = 0;
                        o.done = 1'b1;
                    end
                end
            end else begin
                m_ps = m_ps + 1;
            end
        end
        o.count = 8'(m_count);
        o.busy  = m_run;
        return o;
    endfunction

    task automatic cmp_out(input string name, input out_t got, input out_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got count=%0d busy=%b tick=%b done=%b, want count=%0d busy=%b tick=%b done=%b",
                     name, got.count, got.busy, got.tick, got.done,
                     want.count, want.busy, want.tick, want.done);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, and compare after the edge.
    task automatic cycle(input logic st, input logic sp, input logic per, input logic [7:0] lv,
                         input out_t want, input string name);
        out_t got;
        out_t exp_o;
        start = st; stop = sp; periodic = per; load_val = lv;
        sb_q.push_back(want);
        @(posedge clk);
        #1;
        got   = {count, busy, tick, done};
        exp_o = sb_q.pop_front();
        cmp_out(name, got, exp_o);
    endtask

    task automatic mstep(input logic st, input logic sp, input logic per, input logic [7:0] lv,
                         input string name);
        out_t e;
        e = m_step(st, sp, per, lv);
        cycle(st, sp, per, lv, e, name);
    endtask

    // Load, then check that tick intervals equal (N+1)*prescale for nticks ticks.
    task automatic measure(input logic per, input logic [7:0] lv, input int nticks, input string name);
        int since;
        int seen;
        int budget;
        int want;
        since  = 0;
        seen   = 0;
        want   = (int'(lv) + 1) * PS_DIV;
        budget = want * (nticks + 1) + 4;
        mstep(1'b1, 1'b0, per, lv, {name, "_load"});
        while (seen < nticks && budget > 0) begin
            mstep(1'b0, 1'b0, per, lv, name);
            since++;
            budget--;
            if (tick) begin
                total++;
                if (since != want) begin
                    bad++;
                    $display("FAIL %s_period: got %0d clocks, want %0d", name, since, want);
                end
                seen++;
                since = 0;
            end
        end
        if (seen < nticks) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d ticks, want %0d", name, seen, nticks);
        end
    endtask

    task automatic add(input logic st, input logic sp, input logic per, input logic [7:0] lv,
                       input logic [7:0] c, input logic b, input logic t, input logic d);
        vec_t v;
        v.start = st; v.stop = sp; v.periodic = per; v.load_val = lv;
        v.want  = {c, b, t, d};
        vt.push_back(v);
    endtask

    initial begin
        out_t zero_o;
        zero_o   = '0;
        rstn     = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        periodic = 1'b0;
        load_val = 8'd0;
        m_reset();

        // Reset state, then release away from the clock edge.
        #12;
        cmp_out("reset_state", {count, busy, tick, done}, zero_o);
        #11 rstn = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) mstep(1'b0, 1'b0, 1'b0, 8'd0, "idle_after_reset");

`ifndef TFF_TIMER_PRESCALE_EN
        // One-shot N=3.
        add(1,0,0,3, 3,1,0,0);
        add(0,0,0,3, 2,1,0,0);
        add(0,0,0,3, 1,1,0,0);
        add(0,0,0,3, 0,1,0,0);
        add(0,0,0,3, 0,0,1,1);
        add(0,0,0,3, 0,0,0,0);
        // start and stop together in IDLE.
        add(1,1,1,5, 0,0,0,0);
        // Stop at count=1.
        add(1,0,1,4, 4,1,0,0);
        add(0,0,1,4, 3,1,0,0);
        add(0,0,1,4, 2,1,0,0);
        add(0,0,1,4, 1,1,0,0);
        add(0,1,1,4, 0,0,0,0);
        add(0,0,1,4, 0,0,0,0);
        // Restart with 6 at count=2, then tick 7 clocks later.
        add(1,0,0,3, 3,1,0,0);
        add(0,0,0,3, 2,1,0,0);
        add(1,0,0,6, 6,1,0,0);
        add(0,0,0,6, 5,1,0,0);
        add(0,0,0,6, 4,1,0,0);
        add(0,0,0,6, 3,1,0,0);
        add(0,0,0,6, 2,1,0,0);
        add(0,0,0,6, 1,1,0,0);
        add(0,0,0,6, 0,1,0,0);
        add(0,0,0,6, 0,0,1,1);
        // start and stop together in RUN.
        add(1,0,1,2, 2,1,0,0);
        add(1,1,1,2, 0,0,0,0);
        // start held high acts as a hold.
        add(1,0,1,2, 2,1,0,0);
        add(1,0,1,2, 2,1,0,0);
        add(1,0,1,2, 2,1,0,0);
        add(0,0,1,2, 1,1,0,0);
        add(0,0,1,2, 0,1,0,0);
        add(0,0,1,2, 2,1,1,0);
        add(0,1,1,2, 0,0,0,0);
        // periodic resampled at reload: second period becomes one-shot.
        add(1,0,1,1, 1,1,0,0);
        add(0,0,0,1, 0,1,0,0);
        add(0,0,0,1, 1,1,1,0);
        add(0,0,0,1, 0,1,0,0);
        add(0,0,0,1, 0,0,1,1);
        add(0,0,0,1, 0,0,0,0);
        for (int i = 0; i < vt.size(); i++) begin
            cycle(vt[i].start, vt[i].stop, vt[i].periodic, vt[i].load_val, vt[i].want,
                  $sformatf("vec%0d", i));
        end
        m_reset();
`endif

        // Periodic N=2, then load_val changes to 4 mid-period.
        mstep(1'b1, 1'b0, 1'b1, 8'd2, "per_load");
        repeat (7 * PS_DIV) mstep(1'b0, 1'b0, 1'b1, 8'd2, "per_n2");
        repeat (25 * PS_DIV) mstep(1'b0, 1'b0, 1'b1, 8'd4, "per_n4");
        mstep(1'b0, 1'b1, 1'b1, 8'd4, "per_stop");

        measure(1'b1, 8'd2, 4, "period_n2");
        mstep(1'b0, 1'b1, 1'b0, 8'd0, "stop_a");
        measure(1'b1, 8'd0, 4, "period_n0");
        mstep(1'b0, 1'b1, 1'b0, 8'd0, "stop_b");
        measure(1'b1, 8'd1, 3, "period_n1");
        mstep(1'b0, 1'b1, 1'b0, 8'd0, "stop_c");
        measure(1'b0, 8'd255, 1, "oneshot_255");
        repeat (2) mstep(1'b0, 1'b0, 1'b0, 8'd255, "oneshot_255_hold");
        measure(1'b0, 8'd0, 1, "oneshot_0");
        mstep(1'b0, 1'b0, 1'b0, 8'd0, "oneshot_0_idle");

        // Asynchronous reset mid-count.
        mstep(1'b1, 1'b0, 1'b1, 8'd8, "rst_load");
        repeat (3) mstep(1'b0, 1'b0, 1'b1, 8'd8, "rst_run");
        rstn = 1'b0;
        #2;
        cmp_out("async_reset", {count, busy, tick, done}, zero_o);
        m_reset();
        #1 rstn = 1'b1;
        repeat (4) mstep(1'b0, 1'b0, 1'b1, 8'd8, "idle_after_midrun_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
